// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: game-flow controller for the pong VGA pipeline.
// Samples the ball position once per frame, detects edge misses, keeps the
// two scores and sequences idle / serve / play / point / game-over.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high
//   frame_tick  one-clock pulse per frame
//   ball_x      ball left x in pixels, valid with frame_tick
//   serve_btn   raw asynchronous serve/restart button
//   score1/2    player scores, saturate at MAX_SCORE+1
//   ball_run    ball layer may move
//   ball_reset  one-clock pulse that re-centres the ball
//   smerx       serve direction (0 = toward left, 1 = toward right)
//   game_over   high while in the game-over state
//   winner      0 = player 1, 1 = player 2; valid while game_over is high
module pong_score_ctrl #(
  parameter int unsigned MAX_SCORE    = 5,
  parameter int unsigned LEFT_EDGE    = 0,
  parameter int unsigned RIGHT_EDGE   = 639,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned DEBOUNCE     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic       serve_btn,
  output logic [9:0] score1,
  output logic [9:0] score2,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       smerx,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned CntMax = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned DebW   = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [CntW-1:0] PointLast = CntW'(POINT_FRAMES - 1);
  localparam logic [DebW-1:0] DebLast   = DebW'(DEBOUNCE - 1);
  localparam logic [DebW-1:0] DebSat    = DebW'(DEBOUNCE);
  localparam logic [9:0]      WinScore  = 10'(MAX_SCORE + 1);
  localparam logic [9:0]      LeftEdge  = 10'(LEFT_EDGE);
  localparam logic [9:0]      RightEdge = 10'(RIGHT_EDGE);

  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPoint, StOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DebW-1:0] deb_q, deb_d;
  logic            btn_meta_q, btn_sync_q;
  logic [9:0]      score1_q, score1_d, score2_q, score2_d;
  logic            ball_run_q, ball_run_d;
  logic            ball_reset_q, ball_reset_d;
  logic            smerx_q, smerx_d;
  logic            game_over_q, game_over_d;
  logic            winner_q, winner_d;
  logic            press;

  // Debounce: count consecutive high samples per frame; saturate so a held
  // button produces a single press.
  always_comb begin
    deb_d = deb_q;
    if (frame_tick) begin
      if (!btn_sync_q)        deb_d = '0;
      else if (deb_q != DebSat) deb_d = deb_q + DebW'(1);
    end
  end

  assign press = frame_tick & btn_sync_q & (deb_q == DebLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    ball_run_d   = ball_run_q;
    ball_reset_d = 1'b0;
    smerx_d      = smerx_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          ball_reset_d = 1'b1;
          cnt_d        = '0;
          state_d      = StServe;
        end
      end
      StServe: begin
        if (frame_tick) begin
          if (cnt_q == ServeLast) begin
            state_d    = StPlay;
            ball_run_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        if (frame_tick) begin
          // Left miss wins if both edge tests fire.
          if (ball_x <= LeftEdge) begin
            if (score2_q < WinScore) score2_d = score2_q + 10'd1;
            smerx_d    = 1'b0;
            ball_run_d = 1'b0;
            cnt_d      = '0;
            state_d    = StPoint;
          end else if (ball_x >= RightEdge) begin
            if (score1_q < WinScore) score1_d = score1_q + 10'd1;
            smerx_d    = 1'b1;
            ball_run_d = 1'b0;
            cnt_d      = '0;
            state_d    = StPoint;
          end
        end
      end
      StPoint: begin
        if (frame_tick) begin
          if (cnt_q == PointLast) begin
            if ((score1_q >= WinScore) || (score2_q >= WinScore)) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              winner_d    = (score2_q >= WinScore);
            end else begin
              ball_reset_d = 1'b1;
              cnt_d        = '0;
              state_d      = StServe;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StOver: begin
        if (press) begin
          score1_d     = '0;
          score2_d     = '0;
          game_over_d  = 1'b0;
          winner_d     = 1'b0;
          ball_reset_d = 1'b1;
          cnt_d        = '0;
          state_d      = StServe;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      deb_q        <= '0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      smerx_q      <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      deb_q        <= deb_d;
      btn_meta_q   <= serve_btn;
      btn_sync_q   <= btn_meta_q;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      smerx_q      <= smerx_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign score1     = score1_q;
  assign score2     = score2_q;
  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign smerx      = smerx_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl: walks a full game from reset through
// serve, points, game over, restart and a mid-game reset.
module tb_pong_score_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic       serve_btn = 1'b0;
  logic [9:0] score1, score2;
  logic       ball_run, ball_reset, smerx, game_over, winner;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int max_s1 = 0;

  pong_score_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .ball_x     (ball_x),
    .serve_btn  (serve_btn),
    .score1     (score1),
    .score2     (score2),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .smerx      (smerx),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clock = ~clock;

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (ball_reset === 1'b1) pulse_cnt++;
    if (int'(score1) > max_s1) max_s1 = int'(score1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    step();
    tests++;
    if ({score1, score2} !== 20'd0) begin
      fails++; $display("FAIL reset_scores got %0d/%0d want 0/0", score1, score2);
    end
    tests++;
    if ({ball_run, ball_reset, smerx, game_over, winner} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
               {ball_run, ball_reset, smerx, game_over, winner});
    end
    pulse_cnt = 0;
    ball_x = 10'd0;
    frames(5);
    tests++;
    if ({ball_run, game_over, score2} !== 12'd0 || pulse_cnt != 0) begin
      fails++;
      $display("FAIL idle_ticks got run=%b over=%b s2=%0d pulses=%0d want all 0",
               ball_run, game_over, score2, pulse_cnt);
    end
    ball_x = 10'd320;
  endtask

  task automatic test_serve();
    pulse_cnt = 0;
    serve_btn = 1'b1;
    step(); step(); step();
    frames(3);
    serve_btn = 1'b0;
    tests++;
    if (pulse_cnt != 1) begin
      fails++; $display("FAIL serve_pulse got %0d want 1", pulse_cnt);
    end
    frames(59);
    tests++;
    if (ball_run !== 1'b0) begin
      fails++; $display("FAIL serve_early got ball_run=%b want 0", ball_run);
    end
    frames(1);
    tests++;
    if (ball_run !== 1'b1) begin
      fails++; $display("FAIL serve_release got ball_run=%b want 1", ball_run);
    end
  endtask

  task automatic test_left_point();
    // Just inside both edges: no point.
    ball_x = 10'd1;   frames(1);
    ball_x = 10'd638; frames(1);
    tests++;
    if ({score1, score2} !== 20'd0 || ball_run !== 1'b1) begin
      fails++;
      $display("FAIL near_edge got s1=%0d s2=%0d run=%b want 0 0 1", score1, score2, ball_run);
    end
    ball_x = 10'd0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    tests++;
    if (score2 !== 10'd1 || smerx !== 1'b0 || ball_run !== 1'b0 || score1 !== 10'd0) begin
      fails++;
      $display("FAIL left_point got s2=%0d smerx=%b run=%b s1=%0d want 1 0 0 0",
               score2, smerx, ball_run, score1);
    end
    step();
    ball_x = 10'd320;
    pulse_cnt = 0;
    frames(29);
    tests++;
    if (pulse_cnt != 0) begin
      fails++; $display("FAIL point_early got pulses=%0d want 0", pulse_cnt);
    end
    frames(1);
    tests++;
    if (pulse_cnt != 1) begin
      fails++; $display("FAIL point_reserve got pulses=%0d want 1", pulse_cnt);
    end
    frames(60);
  endtask

  task automatic test_game_over();
    max_s1 = 0;
    for (int i = 0; i < 6; i++) begin
      ball_x = 10'd639; frames(1);
      tests++;
      if (score1 !== 10'(i + 1) || smerx !== 1'b1) begin
        fails++;
        $display("FAIL right_point%0d got s1=%0d smerx=%b want %0d 1", i, score1, smerx, i + 1);
      end
      ball_x = 10'd320; frames(30);
      if (i < 5) frames(60);
    end
    tests++;
    if (game_over !== 1'b1 || winner !== 1'b0 || score2 !== 10'd1) begin
      fails++;
      $display("FAIL game_over got over=%b winner=%b s2=%0d want 1 0 1",
               game_over, winner, score2);
    end
    ball_x = 10'd639;
    frames(5);
    ball_x = 10'd320;
    tests++;
    if (score1 !== 10'd6 || max_s1 > 6 || ball_run !== 1'b0) begin
      fails++;
      $display("FAIL score_hold got s1=%0d max=%0d run=%b want 6 6 0", score1, max_s1, ball_run);
    end
  endtask

  task automatic test_restart_hold();
    pulse_cnt = 0;
    serve_btn = 1'b1;
    step(); step(); step();
    frames(200);
    serve_btn = 1'b0;
    frames(2);
    tests++;
    if (pulse_cnt != 1) begin
      fails++; $display("FAIL restart_pulses got %0d want 1", pulse_cnt);
    end
    tests++;
    if ({score1, score2} !== 20'd0 || game_over !== 1'b0 || winner !== 1'b0) begin
      fails++;
      $display("FAIL restart_clear got s1=%0d s2=%0d over=%b win=%b want 0 0 0 0",
               score1, score2, game_over, winner);
    end
    tests++;
    if (ball_run !== 1'b1) begin
      fails++; $display("FAIL restart_play got ball_run=%b want 1", ball_run);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      ball_x = 10'd639; frames(1);
      ball_x = 10'd320; frames(90);
    end
    tests++;
    if (score1 !== 10'd3 || ball_run !== 1'b1) begin
      fails++; $display("FAIL pre_reset got s1=%0d run=%b want 3 1", score1, ball_run);
    end
    pulse_cnt = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (score1 !== 10'd0 || ball_run !== 1'b0 || ball_reset !== 1'b0 || pulse_cnt != 0) begin
      fails++;
      $display("FAIL mid_reset got s1=%0d run=%b rst=%b pulses=%0d want 0 0 0 0",
               score1, ball_run, ball_reset, pulse_cnt);
    end
    // In IDLE an edge hit must not score.
    ball_x = 10'd0;
    frames(5);
    tests++;
    if (score2 !== 10'd0 || pulse_cnt != 0) begin
      fails++; $display("FAIL post_reset_idle got s2=%0d pulses=%0d want 0 0", score2, pulse_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_left_point();
    test_game_over();
    test_restart_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
